// File: rtl/tcam_lookup_arbiter.sv
// tcam_lookup_arbiter: round-robin sharing of a single TCAM lookup port.
// Define TCAM_ARB_TIMEOUT_EN to add a WAIT_RES response timeout.
module tcam_lookup_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 192,
  parameter int DEST_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IW            = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tcam_init_done,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   s_req_key,
  output logic [NUM_REQ-1:0]             s_req_ready,
  output logic [NUM_REQ-1:0]             s_res_valid,
  output logic                           s_res_null,
  output logic [DEST_WIDTH-1:0]          s_res_data,
  output logic                           m_tcam_req_valid,
  input  logic                           m_tcam_req_ready,
  output logic [KEY_WIDTH-1:0]           m_tcam_req_key,
  input  logic                           m_tcam_res_valid,
  input  logic                           m_tcam_res_null,
  input  logic [DEST_WIDTH-1:0]          m_tcam_res_data,
  output logic [IW-1:0]                  grant_idx,
  output logic                           busy,
  output logic [31:0]                    timeout_count
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RES, RESPOND
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic                  res_null_q, res_null_d;
  logic [DEST_WIDTH-1:0] res_data_q, res_data_d;
  logic [IW-1:0]         win;
  logic                  win_vld;
  logic                  tmo_hit;

  always_comb begin : rr_pick
    int j;
    j       = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_vld && s_req_valid[j]) begin
        win_vld = 1'b1;
        win     = IW'(j);
      end
    end
  end

`ifdef TCAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]   tmo_total_q, tmo_total_d;

  assign tmo_hit = (state_q == WAIT_RES) &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside WAIT_RES, so entry always starts clean.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_total_d = tmo_total_q;
    if (state_q != WAIT_RES) begin
      tmo_cnt_d = '0;
    end else if (!tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (tmo_hit && !m_tcam_res_valid && (tmo_total_q != '1)) begin
      tmo_total_d = tmo_total_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      tmo_total_q <= '0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_total_q <= tmo_total_d;
    end
  end

  assign timeout_count = tmo_total_q;
`else
  assign tmo_hit       = 1'b0;
  assign timeout_count = 32'd0;
`endif

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    key_d            = key_q;
    res_null_d       = res_null_q;
    res_data_d       = res_data_q;
    m_tcam_req_valid = 1'b0;
    m_tcam_req_key   = '0;
    s_req_ready      = '0;
    s_res_valid      = '0;
    s_res_null       = 1'b0;
    s_res_data       = '0;
    unique case (state_q)
      IDLE: begin
        if (tcam_init_done && win_vld) begin
          grant_d = win;
          key_d   = s_req_key[int'(win)*KEY_WIDTH +: KEY_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_tcam_req_valid = 1'b1;
        m_tcam_req_key   = key_q;
        if (m_tcam_req_ready) begin
          s_req_ready[grant_q] = 1'b1;
          state_d              = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A response coinciding with the timeout is taken as real.
        if (m_tcam_res_valid) begin
          res_null_d = m_tcam_res_null;
          res_data_d = m_tcam_res_data;
          state_d    = RESPOND;
        end else if (tmo_hit) begin
          res_null_d = 1'b1;
          res_data_d = '0;
          state_d    = RESPOND;
        end
      end
      RESPOND: begin
        s_res_valid[grant_q] = 1'b1;
        s_res_null           = res_null_q;
        s_res_data           = res_data_q;
        rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      key_q      <= '0;
      res_null_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      key_q      <= key_d;
      res_null_q <= res_null_d;
      res_data_q <= res_data_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/tcam_lookup_arbiter.md
# tcam_lookup_arbiter

Shares the single TCAM lookup port between `NUM_REQ` packet-dispatcher FSMs. Requests are granted round-robin, and only one lookup is outstanding at a time. Each result (match data or null) is routed back to the requester that issued it. No lookups are granted until TCAM initialisation completes. The block sits between the per-port dispatchers and the TCAM wrapper.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `KEY_WIDTH`, 192: lookup key width (matches the dispatcher buffer width).
- `DEST_WIDTH`, 3: result (tdest) width.
- `TIMEOUT_CYCLES`, 64: response timeout, in cycles; ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tcam_init_done` in 1: TCAM initialisation complete.
- `s_req_valid` in NUM_REQ: per-requester lookup request.
- `s_req_key` in NUM_REQ*KEY_WIDTH: per-requester key; requester i uses slice i.
- `s_req_ready` out NUM_REQ: request accepted (one-hot pulse).
- `s_res_valid` out NUM_REQ: result strobe (one-hot pulse).
- `s_res_null` out 1: result is a miss; shared, qualified by `s_res_valid`.
- `s_res_data` out DEST_WIDTH: result dest; shared, qualified by `s_res_valid`.
- `m_tcam_req_valid` out 1: TCAM request.
- `m_tcam_req_ready` in 1: TCAM accepts the request.
- `m_tcam_req_key` out KEY_WIDTH: key to the TCAM.
- `m_tcam_res_valid` in 1: TCAM result strobe.
- `m_tcam_res_null` in 1: TCAM miss.
- `m_tcam_res_data` in DEST_WIDTH: TCAM result.
- `grant_idx` out clog2(NUM_REQ): current or last granted requester.
- `busy` out 1: state ≠ IDLE.
- `timeout_count` out 32: saturating count of timed-out lookups.

## Operation
The state machine has four states: IDLE, ISSUE, WAIT_RES, RESPOND.

**IDLE**
- Grants only while `tcam_init_done`=1 and at least one `s_req_valid` is high.
- Winner: the first valid requester searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
- On grant: latch `grant_idx` and that requester's key into `key_reg`, then go to ISSUE.

**ISSUE**
- `m_tcam_req_valid`=1 and `m_tcam_req_key`=`key_reg`.
- When `m_tcam_req_ready`=1: `s_req_ready[grant_idx]`=1 combinationally in the same cycle, then go to WAIT_RES.

**WAIT_RES**
- On `m_tcam_res_valid`: latch null and data, then go to RESPOND.

**RESPOND**
- Drive `s_res_valid[grant_idx]`=1 for exactly one cycle, with `s_res_null` and `s_res_data` from the latch.
- Set `rr_ptr` = `grant_idx`+1, wrapping modulo `NUM_REQ`.
- Go to IDLE.

**Requester rules**
- A requester holds `s_req_valid` and its key until `s_req_ready`.
- The key is latched at grant, so a requester that drops valid after grant still gets exactly one response.

**Other rules**
- A `m_tcam_res_valid` arriving in IDLE, ISSUE or RESPOND is ignored.
- `tcam_init_done` is sampled only in IDLE. A fall mid-lookup does not abort the lookup.
- Outputs are zero whenever they are not being driven.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant_idx` 0, `key_reg` 0, `timeout_count` 0.
  - All valid, ready and strobe outputs 0; `s_res_null` 0; `s_res_data` 0; `busy` 0.
- Reset mid-lookup discards the outstanding lookup. No response is delivered to the requester.
- Request at cycle 0 in IDLE → `m_tcam_req_valid` at cycle 1.
- TCAM response at cycle t → `s_res_valid` at t+1 → IDLE at t+2 → next grant decided at t+2 → issued at t+3.
- Best-case per-lookup occupancy is 4 cycles when the TCAM accepts and responds in one cycle each.
- `m_tcam_req_valid` stays asserted, and `m_tcam_req_key` stays stable, until `m_tcam_req_ready`.
- Simultaneous requests are served strictly round-robin. No requester waits more than `NUM_REQ`-1 other lookups.

## Configuration
- `TCAM_ARB_TIMEOUT_EN` defined:
  - WAIT_RES runs a counter that is cleared on entry.
  - If `TIMEOUT_CYCLES` cycles pass without `m_tcam_res_valid`, go to RESPOND with `s_res_null`=1 and `s_res_data`=0.
  - `timeout_count` increments, saturating at 2^32-1.
  - A response arriving in the same cycle as the timeout wins: it is a normal response, not a timeout.
  - A late response that arrives afterwards is ignored.
- `TCAM_ARB_TIMEOUT_EN` undefined:
  - WAIT_RES waits indefinitely.
  - `timeout_count` is constant 0.

## Test plan
- **Init gating:** `tcam_init_done`=0, requester 1 valid for 20 cycles → no `m_tcam_req_valid`. Raise init → `m_tcam_req_valid` one cycle later, carrying key1.
- **Fairness:** all four requesters valid continuously, TCAM responds data=i+1 → grant order 0,1,2,3,0. Each `s_res_valid[i]` carries data i+1.
- **Request backpressure:** `m_tcam_req_ready` low for 5 cycles → valid and key held stable; `s_req_ready[g]` pulses only in the accept cycle.
- **Miss routing:** requester 2 gets `m_tcam_res_null`=1 → `s_res_valid[2]`=1 with `s_res_null`=1, for one cycle. No other `s_res_valid` bit is set.
- **Timeout (`TCAM_ARB_TIMEOUT_EN` defined):** no response → null result exactly `TIMEOUT_CYCLES` cycles after WAIT_RES entry; `timeout_count`=1. A late response 3 cycles later is ignored.
- **Reset mid-lookup:** `rst` pulsed in WAIT_RES → IDLE, `rr_ptr`=0, no `s_res_valid`. A stray TCAM response after reset is ignored.
